// File: rtl/ysyx_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package ysyx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Byte-lane view of a store after moving it to its offset in the word.
  // mask[7:4] nonzero means the store spills into the next word.
  typedef struct packed {
    logic [7:0]  mask;
    logic [31:0] data;
  } lane_t;

  function automatic lane_t lane_shift(input logic [3:0]  wmask,
                                       input logic [31:0] wdata,
                                       input logic [1:0]  off);
    lane_t l;
    l.mask = {4'b0000, wmask} << off;
    l.data = wdata << {off, 3'b000};
    return l;
  endfunction

endpackage

// File: rtl/ysyx_dmem_array.sv
// Byte-enabled word array with one write port and one registered read port.
// Contents are never reset so the block can be swapped for an SRAM macro.
module ysyx_dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] widx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Byte-enabled write; read data only updates on a read strobe so it holds
  // steady for as long as the response is stalled.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata_q <= mem[ridx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_dmem_resp.sv
// Fixed-latency data-memory slave: one request in flight, byte-masked stores,
// aligned word loads, range/straddle error reporting.
module ysyx_dmem_resp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  import ysyx_mem_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT4 = 4'(LATENCY);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic        err_q, rd_ok_q;

  logic        accept, entry, err;
  logic [29:0] idx_full;
  lane_t       lane;
  logic [31:0] arr_rdata;

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // The edge leaving WAIT with an expired counter is the single commit point.
  assign entry     = (state_q == WAIT) && (cnt_q == 4'd0);

  // Next-state and countdown. WAIT is always visited so that the commit edge
  // is distinct from the accept edge; with LATENCY=0 it lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        cnt_d   = LAT4;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch, captured on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  // Address decode and lane placement for the latched request.
  assign idx_full = addr_q[31:2] - BASE[31:2];
  assign lane     = lane_shift(wmask_q, wdata_q, addr_q[1:0]);
  assign err      = (addr_q < BASE) || ({2'b00, idx_full} >= 32'(DEPTH)) ||
                    (wen_q && (lane.mask[7:4] != 4'b0000));

  // Response flags, fixed at the commit edge and held through any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (entry) begin
      err_q   <= err;
      rd_ok_q <= !wen_q && !err;
    end
  end

  ysyx_dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (entry && wen_q && !err && !rst),
    .widx  (idx_full[AW-1:0]),
    .be    (lane.mask[3:0]),
    .wdata (lane.data),
    .re    (entry && !wen_q && !err && !rst),
    .ridx  (idx_full[AW-1:0]),
    .rdata (arr_rdata)
  );

  assign resp_valid = (state_q == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rd_ok_q ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_ysyx_dmem_resp.sv
// Directed bench for ysyx_dmem_resp: LATENCY=2 instance plus a LATENCY=0 one.
module tb_ysyx_dmem_resp;
  import ysyx_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wen, resp_ready, sel;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;

  logic        a_ready, a_valid, a_err, b_ready, b_valid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        ready, valid, err;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_dmem_resp #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(a_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(a_valid), .resp_ready(resp_ready),
    .resp_rdata(a_rdata), .resp_err(a_err)
  );

  ysyx_dmem_resp #(.LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(b_ready),
    .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wmask(req_wmask), .resp_valid(b_valid), .resp_ready(resp_ready),
    .resp_rdata(b_rdata), .resp_err(b_err)
  );

  assign ready = sel ? b_ready : a_ready;
  assign valid = sel ? b_valid : a_valid;
  assign rdata = sel ? b_rdata : a_rdata;
  assign err   = sel ? b_err   : a_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after an acceptance edge; counts edges until resp_valid.
  task automatic wait_resp(input string tag, input int lat);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!valid && cyc < 40);
    check({tag, ".lat"}, 32'(cyc), 32'(lat + 1));
  endtask

  // Full transaction: present, accept, wait, capture, handshake.
  task automatic xact(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] m, input int lat,
                      input logic [31:0] exp_rd, input logic exp_err);
    int n;
    @(negedge clk);
    req_wen = w; req_addr = a; req_wdata = d; req_wmask = m; req_valid = 1'b1;
    n = 0;
    while (!ready && n < 40) begin @(negedge clk); n++; end
    check({tag, ".rdy"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(tag, lat);
    check({tag, ".rdata"}, rdata, exp_rd);
    check({tag, ".err"}, 32'(err), {31'd0, exp_err});
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, ".drop"}, 32'(valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.valid", 32'(valid), 32'd0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.err",   32'(err), 32'd0);
    rst = 1'b0; #1;
    check("rst.ready_after", 32'(ready), 32'd1);

    // Word, byte and half stores merged into one word.
    xact("st_w",  1'b1, 32'h8000_0010, 32'hDEAD_BEEF, MASK_W, 2, 32'h0, 1'b0);
    xact("ld_w",  1'b0, 32'h8000_0010, 32'h0,         MASK_W, 2, 32'hDEAD_BEEF, 1'b0);
    xact("st_b",  1'b1, 32'h8000_0013, 32'h0000_00AB, MASK_B, 2, 32'h0, 1'b0);
    xact("ld_b",  1'b0, 32'h8000_0010, 32'h0,         MASK_W, 2, 32'hABAD_BEEF, 1'b0);
    xact("st_h",  1'b1, 32'h8000_0012, 32'h0000_1234, MASK_H, 2, 32'h0, 1'b0);
    xact("ld_h",  1'b0, 32'h8000_0010, 32'h0,         MASK_W, 2, 32'h1234_BEEF, 1'b0);

    // Straddling store and out-of-range accesses.
    xact("st_str", 1'b1, 32'h8000_0013, 32'h0000_FFFF, MASK_H, 2, 32'h0, 1'b1);
    xact("ld_str", 1'b0, 32'h8000_0010, 32'h0,         MASK_W, 2, 32'h1234_BEEF, 1'b0);
    xact("ld_lo",  1'b0, 32'h7FFF_FFFC, 32'h0,         MASK_W, 2, 32'h0, 1'b1);
    xact("ld_hi",  1'b0, 32'h8000_1000, 32'h0,         MASK_W, 2, 32'h0, 1'b1);
    xact("st_top", 1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, MASK_W, 2, 32'h0, 1'b0);
    xact("ld_top", 1'b0, 32'h8000_0FFC, 32'h0,         MASK_W, 2, 32'h0BAD_F00D, 1'b0);

    // Backpressure, with a second request held during the stall.
    @(negedge clk);
    req_wen = 1'b0; req_addr = 32'h8000_0010; req_wmask = MASK_W; req_valid = 1'b1;
    check("bp.rdy", 32'(ready), 32'd1);
    @(posedge clk); #1;
    req_addr = 32'h8000_0012;
    wait_resp("bp", 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.valid", 32'(valid), 32'd1);
      check("bp.rdata", rdata, 32'h1234_BEEF);
      check("bp.ready", 32'(ready), 32'd0);
    end
    @(negedge clk) resp_ready = 1'b1;
    check("bp.hs_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp.drop", 32'(valid), 32'd0);
    check("bp.idle_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp("bp2", 2);
    check("bp2.rdata", rdata, 32'h1234_BEEF);
    @(negedge clk) resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset one cycle after accepting a store: no response, no write.
    @(negedge clk);
    req_wen = 1'b1; req_addr = 32'h8000_0010; req_wdata = 32'h55; req_wmask = MASK_B;
    req_valid = 1'b1;
    check("rw.rdy", 32'(ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rw.novalid", 32'(valid), 32'd0);
    end
    check("rw.ready", 32'(ready), 32'd1);
    xact("rw.ld", 1'b0, 32'h8000_0010, 32'h0, MASK_W, 2, 32'h1234_BEEF, 1'b0);

    // LATENCY=0 instance.
    sel = 1'b1;
    xact("l0.st", 1'b1, 32'h8000_0020, 32'hDEAD_BEEF, MASK_W, 0, 32'h0, 1'b0);
    xact("l0.ld", 1'b0, 32'h8000_0020, 32'h0,         MASK_W, 0, 32'hDEAD_BEEF, 1'b0);
    xact("l0.ldb", 1'b0, 32'h8000_0023, 32'h0,        MASK_B, 0, 32'hDEAD_BEEF, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
